// File: rtl/serial_addsub.sv
// Serial add/subtract unit. Processes SLICE bits of the operands per clock,
// LSB slice first, with the inter-slice carry/borrow held in a register.
// Result and flags are published together on the final slice and held
// until the next operation finishes.
module serial_addsub #(
    parameter int DATASIZE = 8,
    parameter int SLICE    = 2
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iStart,
    input  logic                iSub,
    input  logic [DATASIZE-1:0] iJ,
    input  logic [DATASIZE-1:0] iK,
    input  logic                iCB,
    output logic                oBusy,
    output logic                oDone,
    output logic [DATASIZE-1:0] oD,
    output logic                oCB,
    output logic                oZ,
    output logic                oS,
    output logic                oP,
    output logic                oAC,
    output logic                oV
);

    localparam int N        = DATASIZE / SLICE;
    localparam int CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam int IDX_W    = $clog2(DATASIZE);
    localparam int AC_BIT   = DATASIZE / 2 - 1;
    localparam int AC_SLICE = AC_BIT / SLICE;
    localparam int AC_POS   = AC_BIT % SLICE;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] AC_CNT   = CNT_W'(AC_SLICE);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                cb_q;
    logic                ac_q;

    // Operands and partial result: captured/updated only under control
    // qualification, so they carry no reset.
    logic [DATASIZE-1:0] j_q;
    logic [DATASIZE-1:0] k_q;
    logic                sub_q;
    logic [DATASIZE-1:0] res_q;

    logic [IDX_W-1:0]    base;
    logic [SLICE-1:0]    j_sl;
    logic [SLICE-1:0]    k_sl;
    logic [SLICE-1:0]    d_sl;
    logic [SLICE:0]      c_chain;
    logic [DATASIZE-1:0] final_d;
    logic                ac_now;
    logic                v_now;

    // Carry (add) or borrow (subtract) out of one bit position.
    function automatic logic f_carry(input logic sub, input logic j,
                                     input logic k, input logic c);
        if (sub)
            return (~j & k) | (~(j ^ k) & c);
        else
            return (j & k) | ((j ^ k) & c);
    endfunction

    // Signed overflow from the operand and result sign bits.
    function automatic logic f_overflow(input logic sub, input logic jm,
                                        input logic km, input logic dm);
        if (sub)
            return (jm != km) && (dm != jm);
        else
            return (jm == km) && (dm != jm);
    endfunction

    function automatic logic f_zero(input logic [DATASIZE-1:0] d);
        return (d == '0);
    endfunction

    function automatic logic f_parity_even(input logic [DATASIZE-1:0] d);
        return ~(^d);
    endfunction

    // Bit offset of the slice being processed this cycle.
    assign base = IDX_W'(cnt_q) * IDX_W'(SLICE);

    // Ripple through the current slice starting from the registered carry.
    always_comb begin
        j_sl       = j_q[base +: SLICE];
        k_sl       = k_q[base +: SLICE];
        d_sl       = '0;
        c_chain    = '0;
        c_chain[0] = cb_q;
        for (int i = 0; i < SLICE; i++) begin
            d_sl[i]      = j_sl[i] ^ k_sl[i] ^ c_chain[i];
            c_chain[i+1] = f_carry(sub_q, j_sl[i], k_sl[i], c_chain[i]);
        end
    end

    // Full result as it will look once the current slice is merged in;
    // the aux carry bypasses its register when it is produced this cycle.
    always_comb begin
        final_d              = res_q;
        final_d[base +: SLICE] = d_sl;
        ac_now               = (cnt_q == AC_CNT) ? c_chain[AC_POS+1] : ac_q;
        v_now                = f_overflow(sub_q, j_q[DATASIZE-1], k_q[DATASIZE-1],
                                          final_d[DATASIZE-1]);
    end

    assign oBusy = (state_q == RUN);

    // Sequencer: start acceptance, slice counting, and result publication.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cb_q    <= 1'b0;
            ac_q    <= 1'b0;
            oDone   <= 1'b0;
            oD      <= '0;
            oCB     <= 1'b0;
            oZ      <= 1'b0;
            oS      <= 1'b0;
            oP      <= 1'b0;
            oAC     <= 1'b0;
            oV      <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (iStart) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        cb_q    <= iCB;
                    end
                end
                RUN: begin
                    cb_q <= c_chain[SLICE];
                    if (cnt_q == AC_CNT)
                        ac_q <= c_chain[AC_POS+1];
                    if (cnt_q == LAST_CNT) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        oDone   <= 1'b1;
                        oD      <= final_d;
                        oCB     <= c_chain[SLICE];
                        oZ      <= f_zero(final_d);
                        oS      <= final_d[DATASIZE-1];
                        oP      <= f_parity_even(final_d);
                        oAC     <= ac_now;
                        oV      <= v_now;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Operand capture on start and per-slice accumulation of the result.
    always_ff @(posedge iClk) begin
        if (state_q == IDLE && iStart) begin
            j_q   <= iJ;
            k_q   <= iK;
            sub_q <= iSub;
        end else if (state_q == RUN) begin
            res_q[base +: SLICE] <= d_sl;
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub (DATASIZE=8, SLICE=2): table of vectors with
// expected results queued at start and compared at oDone, plus sequences
// for start-while-busy, back-to-back starts and mid-operation reset.
module tb_serial_addsub;

    localparam int DATASIZE = 8;
    localparam int SLICE    = 2;
    localparam int N        = DATASIZE / SLICE;

    logic       iClk = 1'b0;
    logic       iRstN = 1'b0;
    logic       iStart = 1'b0;
    logic       iSub = 1'b0;
    logic       iCB = 1'b0;
    logic [7:0] iJ = 8'h00;
    logic [7:0] iK = 8'h00;
    logic       oBusy, oDone, oCB, oZ, oS, oP, oAC, oV;
    logic [7:0] oD;

    int checks = 0;
    int errors = 0;

    // Expected {d[7:0], cb, z, s, p, ac, v}
    logic [13:0] exp_q[$];

    typedef struct {
        logic        sub;
        logic [7:0]  j;
        logic [7:0]  k;
        logic        cb;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[8];

    serial_addsub #(.DATASIZE(DATASIZE), .SLICE(SLICE)) dut (
        .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .iSub(iSub),
        .iJ(iJ), .iK(iK), .iCB(iCB),
        .oBusy(oBusy), .oDone(oDone), .oD(oD), .oCB(oCB),
        .oZ(oZ), .oS(oS), .oP(oP), .oAC(oAC), .oV(oV)
    );

    always #5 iClk = ~iClk;

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Arithmetic reference model (integer add/subtract, not bit serial).
    function automatic logic [13:0] model(input logic sub, input logic [7:0] j,
                                          input logic [7:0] k, input logic cb);
        int r;
        logic [7:0] d;
        logic co, ac, v;
        if (!sub) begin
            r  = int'(j) + int'(k) + int'(cb);
            co = (r > 255);
            ac = ((int'(j[3:0]) + int'(k[3:0]) + int'(cb)) > 15);
        end else begin
            r  = int'(j) - int'(k) - int'(cb);
            co = (int'(j) < int'(k) + int'(cb));
            ac = (int'(j[3:0]) < int'(k[3:0]) + int'(cb));
        end
        d = r[7:0];
        v = sub ? ((j[7] != k[7]) && (d[7] != j[7])) : ((j[7] == k[7]) && (d[7] != j[7]));
        return {d, co, (d == 8'h00), d[7], ~(^d), ac, v};
    endfunction

    // Drive a start for one edge; called just after an active edge.
    task automatic start_op(input logic sub, input logic [7:0] j, input logic [7:0] k,
                            input logic cb, input logic [13:0] exp);
        iSub = sub; iJ = j; iK = k; iCB = cb; iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        exp_q.push_back(exp);
    endtask

    // Count edges until oDone (bounded), busy cycles, and whether oD held.
    task automatic wait_done(output int edges, output int busy_cyc, output logic held);
        logic [7:0] d0;
        edges = 0; busy_cyc = 0; held = 1'b1; d0 = oD;
        while (oDone !== 1'b1 && edges < 20) begin
            if (oBusy === 1'b1) busy_cyc++;
            if (oD !== d0) held = 1'b0;
            @(posedge iClk); #1;
            edges++;
        end
    endtask

    task automatic check_result(input string tag);
        logic [13:0] e;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s queue: got empty expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, " oD"}, 32'(oD), 32'(e[13:6]));
            check({tag, " oCB"}, 32'(oCB), 32'(e[5]));
            check({tag, " flags zspav"}, 32'({oZ, oS, oP, oAC, oV}), 32'(e[4:0]));
        end
        check({tag, " busy in done cycle"}, 32'(oBusy), 0);
    endtask

    task automatic check_pulse_end(input string tag);
        @(posedge iClk); #1;
        check({tag, " done pulse width"}, 32'(oDone), 0);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int edges, busy_cyc;
        logic held;
        start_op(v.sub, v.j, v.k, v.cb, v.exp);
        wait_done(edges, busy_cyc, held);
        check({tag, " latency"}, 32'(edges), N);
        check({tag, " busy cycles"}, 32'(busy_cyc), N);
        check({tag, " oD held"}, 32'(held), 1);
        check_result(tag);
        check_pulse_end(tag);
    endtask

    initial begin
        int edges, busy_cyc, done_seen;
        logic held;
        logic [13:0] e;

        // Hand-derived vectors; flag order is z,s,p,ac,v.
        vecs[0] = '{1'b1, 8'h05, 8'h07, 1'b0, {8'hFE, 1'b1, 5'b01010}};
        vecs[1] = '{1'b1, 8'h80, 8'h01, 1'b0, {8'h7F, 1'b0, 5'b00011}};
        vecs[2] = '{1'b0, 8'hFF, 8'h01, 1'b0, {8'h00, 1'b1, 5'b10110}};
        vecs[3] = '{1'b1, 8'h00, 8'h00, 1'b1, {8'hFF, 1'b1, 5'b01110}};
        vecs[4] = '{1'b0, 8'h7F, 8'h01, 1'b0, {8'h80, 1'b0, 5'b01011}};
        for (int i = 5; i < 8; i++) begin
            vecs[i].sub = 1'($urandom);
            vecs[i].j   = 8'($urandom);
            vecs[i].k   = 8'($urandom);
            vecs[i].cb  = 1'($urandom);
            vecs[i].exp = model(vecs[i].sub, vecs[i].j, vecs[i].k, vecs[i].cb);
        end

        // Reset state, with the clock running and a start request asserted.
        iStart = 1'b1;
        #2;
        check("reset outputs", 32'({oBusy, oDone, oD, oCB, oZ, oS, oP, oAC, oV}), 0);
        #20;
        iStart = 1'b0;
        check("reset held outputs", 32'({oBusy, oDone, oD, oCB, oZ, oS, oP, oAC, oV}), 0);
        iRstN = 1'b1;
        @(posedge iClk); #1;
        @(posedge iClk); #1;
        check("idle without start", 32'({oBusy, oDone}), 0);

        for (int i = 0; i < 8; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // Start while busy and operand changes after the start edge.
        start_op(1'b1, 8'h05, 8'h07, 1'b0, model(1'b1, 8'h05, 8'h07, 1'b0));
        @(posedge iClk); #1;
        iStart = 1'b1; iSub = 1'b0; iJ = 8'hAA; iK = 8'h11; iCB = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        wait_done(edges, busy_cyc, held);
        check("busy-start latency", 32'(edges + 2), N);
        check("busy-start oD held", 32'(held), 1);
        check_result("busy-start");

        // Start in the oDone cycle: second oDone 5 edges after the first.
        start_op(1'b0, 8'h3C, 8'h0F, 1'b1, model(1'b0, 8'h3C, 8'h0F, 1'b1));
        check("b2b busy gap closed", 32'(oBusy), 1);
        wait_done(edges, busy_cyc, held);
        check("b2b done spacing", 32'(edges + 1), 5);
        check_result("b2b");
        check_pulse_end("b2b");

        // Reset during the third RUN cycle aborts with no oDone.
        start_op(1'b0, 8'h12, 8'h34, 1'b0, 14'h0);
        void'(exp_q.pop_back());
        @(posedge iClk); #1;
        @(posedge iClk); #1;
        #2 iRstN = 1'b0;
        #1;
        check("abort outputs cleared", 32'({oBusy, oDone, oD, oCB, oZ, oS, oP, oAC, oV}), 0);
        @(posedge iClk); #1;
        check("abort outputs held", 32'({oBusy, oDone, oD, oCB, oZ, oS, oP, oAC, oV}), 0);
        #2 iRstN = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge iClk); #1;
            if (oDone === 1'b1 || oBusy === 1'b1) done_seen++;
        end
        check("abort no done", 32'(done_seen), 0);

        e = model(1'b1, 8'h12, 8'h34, 1'b1);
        run_vec("post-reset sub", '{1'b1, 8'h12, 8'h34, 1'b1, e});
        run_vec("post-reset add", '{1'b0, 8'h7F, 8'h7F, 1'b1, model(1'b0, 8'h7F, 8'h7F, 1'b1)});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
